// File: rtl/calc_sequencer_param.sv
// Keypad-driven calculator sequencer: builds decimal operands from key codes,
// latches an operator and computes an exact signed add/sub/mul result.
module calc_sequencer_param #(
  parameter int unsigned WIDTH      = 9,
  parameter int unsigned MAX_DIGITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  output logic [WIDTH-1:0]     operand_a,
  output logic [WIDTH-1:0]     operand_b,
  output logic [1:0]           op_code,
  output logic [2*WIDTH:0]     result,
  output logic                 result_valid,
  output logic                 overflow,
  output logic [2:0]           state
);

  localparam int unsigned RW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned AW = WIDTH + 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPA    = 3'd1,
    S_OPER   = 3'd2,
    S_OPB    = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  operand_a_d, operand_b_d;
  logic [1:0]        op_code_d;
  logic [RW-1:0]     result_d;
  logic              result_valid_d;
  logic              overflow_d;
  logic [CW-1:0]     digit_cnt, digit_cnt_d;

  logic              is_digit, is_op, is_eq, is_clr, cnt_full;
  logic [1:0]        key_op;
  logic [WIDTH-1:0]  key_digit, append_a, append_b;
  logic [RW-1:0]     ext_a, ext_b, alu;

  assign state = state_q;

  // Key decode and digit-append datapath
  assign is_digit  = (key_code <= 4'd9);
  assign is_op     = (key_code >= 4'd10) && (key_code <= 4'd12);
  assign is_eq     = (key_code == 4'd13);
  assign is_clr    = (key_code == 4'd14);
  assign key_op    = 2'(key_code - 4'd10);
  assign key_digit = WIDTH'(key_code);
  assign cnt_full  = (digit_cnt >= CW'(MAX_DIGITS));
  assign append_a  = WIDTH'({4'd0, operand_a} * AW'(10) + AW'(key_code));
  assign append_b  = WIDTH'({4'd0, operand_b} * AW'(10) + AW'(key_code));

  // Exact arithmetic on zero-extended operands; widened so nothing wraps
  assign ext_a = RW'(operand_a);
  assign ext_b = RW'(operand_b);
  always_comb begin
    alu = '0;
    case (op_code)
      2'd0:    alu = ext_a + ext_b;
      2'd1:    alu = ext_a - ext_b;
      2'd2:    alu = ext_a * ext_b;
      default: alu = '0;
    endcase
  end

  // A reused result overflows operand A when negative or above 2^WIDTH-1
  function automatic logic reuse_ovf(input logic [RW-1:0] r);
    return r[RW-1] | (|r[RW-2:WIDTH]);
  endfunction

  // Next-state and next-register logic
  always_comb begin
    state_d     = state_q;
    operand_a_d = operand_a;
    operand_b_d = operand_b;
    op_code_d   = op_code;
    result_d    = result;
    overflow_d  = overflow;
    digit_cnt_d = digit_cnt;

    case (state_q)
      S_IDLE: begin
        if (key_valid && is_digit) begin
          operand_a_d = key_digit;
          digit_cnt_d = CW'(1);
          state_d     = S_OPA;
        end
      end
      S_OPA: begin
        if (key_valid && is_digit && !cnt_full) begin
          operand_a_d = append_a;
          digit_cnt_d = digit_cnt + CW'(1);
        end else if (key_valid && is_op) begin
          op_code_d = key_op;
          state_d   = S_OPER;
        end
      end
      S_OPER: begin
        if (key_valid && is_digit) begin
          operand_b_d = key_digit;
          digit_cnt_d = CW'(1);
          state_d     = S_OPB;
        end else if (key_valid && is_op) begin
          op_code_d = key_op;
        end
      end
      S_OPB: begin
        if (key_valid && is_digit && !cnt_full) begin
          operand_b_d = append_b;
          digit_cnt_d = digit_cnt + CW'(1);
        end else if (key_valid && is_eq) begin
          result_d = alu;
          state_d  = S_RESULT;
        end else if (key_valid && is_op) begin
          result_d    = alu;
          operand_a_d = alu[WIDTH-1:0];
          operand_b_d = '0;
          op_code_d   = key_op;
          overflow_d  = overflow | reuse_ovf(alu);
          state_d     = S_OPER;
        end
      end
      S_RESULT: begin
        if (key_valid && is_digit) begin
          operand_a_d = key_digit;
          operand_b_d = '0;
          digit_cnt_d = CW'(1);
          overflow_d  = 1'b0;
          state_d     = S_OPA;
        end else if (key_valid && is_op) begin
          operand_a_d = result[WIDTH-1:0];
          operand_b_d = '0;
          op_code_d   = key_op;
          overflow_d  = overflow | reuse_ovf(result);
          state_d     = S_OPER;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CLR and illegal encodings both return everything to the reset image
    if ((key_valid && is_clr) ||
        !(state_q inside {S_IDLE, S_OPA, S_OPER, S_OPB, S_RESULT})) begin
      state_d     = S_IDLE;
      operand_a_d = '0;
      operand_b_d = '0;
      op_code_d   = '0;
      result_d    = '0;
      overflow_d  = 1'b0;
      digit_cnt_d = '0;
    end

    result_valid_d = (state_d == S_RESULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      operand_a    <= '0;
      operand_b    <= '0;
      op_code      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      digit_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      operand_a    <= operand_a_d;
      operand_b    <= operand_b_d;
      op_code      <= op_code_d;
      result       <= result_d;
      result_valid <= result_valid_d;
      overflow     <= overflow_d;
      digit_cnt    <= digit_cnt_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer_param.sv
// Directed self-checking bench for calc_sequencer_param (WIDTH=9, MAX_DIGITS=2).
module tb_calc_sequencer_param;

  localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12,
                         K_EQ  = 4'd13, K_CLR = 4'd14, K_RSV = 4'd15;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [8:0]  operand_a, operand_b;
  logic [1:0]  op_code;
  logic [18:0] result;
  logic        result_valid, overflow;
  logic [2:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;

  calc_sequencer_param #(.WIDTH(9), .MAX_DIGITS(2)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
    .result(result), .result_valid(result_valid), .overflow(overflow),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    idle_cycles(2);
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (operand_a !== 9'd0 || operand_b !== 9'd0) begin n_fail++; $display("FAIL reset_ops: got a=%0d b=%0d want 0 0", operand_a, operand_b); end
    n_cmp++; if (result !== 19'd0 || result_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_res: got r=%0d v=%b o=%b want 0 0 0", result, result_valid, overflow); end
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(1);
  endtask

  task automatic test_basic;
    press(4'd1); press(4'd2); press(K_ADD); press(4'd3); press(4'd4);
    n_cmp++; if (result_valid !== 1'b0 || state !== 3'd3) begin n_fail++; $display("FAIL basic_pre_eq: got v=%b s=%0d want 0 3", result_valid, state); end
    press(K_EQ);
    n_cmp++; if (operand_a !== 9'd12 || operand_b !== 9'd34 || op_code !== 2'd0) begin n_fail++; $display("FAIL basic_ops: got a=%0d b=%0d op=%0d want 12 34 0", operand_a, operand_b, op_code); end
    n_cmp++; if (result !== 19'd46 || result_valid !== 1'b1 || state !== 3'd4) begin n_fail++; $display("FAIL basic_res: got r=%0d v=%b s=%0d want 46 1 4", result, result_valid, state); end
  endtask

  task automatic test_digit_limit_overflow;
    press(K_CLR);
    press(4'd1); press(4'd2); press(4'd3);
    n_cmp++; if (operand_a !== 9'd12 || state !== 3'd1) begin n_fail++; $display("FAIL limit_a: got a=%0d s=%0d want 12 1", operand_a, state); end
    press(K_MUL); press(4'd9); press(4'd9); press(K_EQ);
    n_cmp++; if (result !== 19'd1188 || operand_b !== 9'd99) begin n_fail++; $display("FAIL limit_mul: got r=%0d b=%0d want 1188 99", result, operand_b); end
    press(K_MUL);
    n_cmp++; if (operand_a !== 9'd164 || overflow !== 1'b1 || state !== 3'd2 || operand_b !== 9'd0 || op_code !== 2'd2) begin
      n_fail++; $display("FAIL limit_reuse: got a=%0d o=%b s=%0d b=%0d op=%0d want 164 1 2 0 2", operand_a, overflow, state, operand_b, op_code); end
    press(K_CLR);
    n_cmp++; if (operand_a !== 9'd0 || result !== 19'd0 || overflow !== 1'b0 || state !== 3'd0 || op_code !== 2'd0 || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL limit_clr: got a=%0d r=%0d o=%b s=%0d op=%0d v=%b want all 0", operand_a, result, overflow, state, op_code, result_valid); end
  endtask

  task automatic test_negative;
    press(4'd5); press(K_SUB); press(4'd9); press(K_EQ);
    n_cmp++; if (result !== 19'h7FFFC || overflow !== 1'b0) begin n_fail++; $display("FAIL neg_res: got r=%h o=%b want 7fffc 0", result, overflow); end
    press(K_ADD);
    n_cmp++; if (operand_a !== 9'd508 || overflow !== 1'b1 || state !== 3'd2) begin n_fail++; $display("FAIL neg_reuse: got a=%0d o=%b s=%0d want 508 1 2", operand_a, overflow, state); end
    // Overflow stays sticky through a fresh computation, then a digit in RESULT clears it
    press(4'd1); press(K_EQ);
    n_cmp++; if (result !== 19'd509 || overflow !== 1'b1) begin n_fail++; $display("FAIL neg_sticky: got r=%0d o=%b want 509 1", result, overflow); end
    press(4'd3);
    n_cmp++; if (operand_a !== 9'd3 || operand_b !== 9'd0 || overflow !== 1'b0 || state !== 3'd1 || result !== 19'd509) begin
      n_fail++; $display("FAIL neg_digit_in_result: got a=%0d b=%0d o=%b s=%0d r=%0d want 3 0 0 1 509", operand_a, operand_b, overflow, state, result); end
    press(K_CLR);
  endtask

  task automatic test_chaining;
    press(4'd2); press(K_ADD); press(4'd3); press(K_MUL);
    n_cmp++; if (operand_a !== 9'd5 || op_code !== 2'd2 || state !== 3'd2 || operand_b !== 9'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL chain_reuse: got a=%0d op=%0d s=%0d b=%0d o=%b want 5 2 2 0 0", operand_a, op_code, state, operand_b, overflow); end
    press(K_SUB);
    n_cmp++; if (op_code !== 2'd1 || state !== 3'd2) begin n_fail++; $display("FAIL chain_replace: got op=%0d s=%0d want 1 2", op_code, state); end
    press(4'd4); press(K_EQ);
    n_cmp++; if (result !== 19'd1 || state !== 3'd4) begin n_fail++; $display("FAIL chain_res: got r=%0d s=%0d want 1 4", result, state); end
    press(K_CLR);
  endtask

  task automatic test_ignored;
    press(K_ADD); press(K_EQ); press(K_RSV);
    n_cmp++; if (state !== 3'd0 || operand_a !== 9'd0 || op_code !== 2'd0) begin n_fail++; $display("FAIL ign_idle: got s=%0d a=%0d op=%0d want 0 0 0", state, operand_a, op_code); end
    press(4'd6); press(K_MUL); press(4'd7); press(K_EQ);
    n_cmp++; if (result !== 19'd42) begin n_fail++; $display("FAIL ign_mul: got r=%0d want 42", result); end
    press(K_EQ); press(K_RSV);
    idle_cycles(3);
    n_cmp++; if (result !== 19'd42 || state !== 3'd4 || result_valid !== 1'b1 || operand_a !== 9'd6 || operand_b !== 9'd7) begin
      n_fail++; $display("FAIL ign_result: got r=%0d s=%0d v=%b a=%0d b=%0d want 42 4 1 6 7", result, state, result_valid, operand_a, operand_b); end
    press(K_CLR);
  endtask

  task automatic test_async_reset;
    press(4'd7); press(K_ADD); press(4'd3);
    n_cmp++; if (state !== 3'd3 || operand_a !== 9'd7 || operand_b !== 9'd3) begin n_fail++; $display("FAIL async_pre: got s=%0d a=%0d b=%0d want 3 7 3", state, operand_a, operand_b); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0 || operand_a !== 9'd0 || operand_b !== 9'd0 || op_code !== 2'd0 || result !== 19'd0) begin
      n_fail++; $display("FAIL async_now: got s=%0d a=%0d b=%0d op=%0d r=%0d want all 0", state, operand_a, operand_b, op_code, result); end
    @(negedge clk);
    reset = 1'b1;
    press(4'd4); press(K_ADD); press(4'd1); press(K_EQ);
    n_cmp++; if (result !== 19'd5 || result_valid !== 1'b1) begin n_fail++; $display("FAIL async_after: got r=%0d v=%b want 5 1", result, result_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_digit_limit_overflow();
    test_negative();
    test_chaining();
    test_ignored();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_sequencer_param.md
Name: calc_sequencer_param

Overview:
Parametrised keypad-driven calculator sequencer and the next generation of our operand/operator FSM. It accepts one key code per cycle and builds multi-digit decimal operands. It latches an operator, then computes add, subtract or multiply into a widened signed result. Added over the earlier FSM: configurable operand width and digit count, operator chaining, result reuse as the next operand, clear, and a sticky overflow flag. It sits between the keypad decoder and the display driver.

Parameters:
WIDTH, 9, operand width in bits (unsigned operands).
MAX_DIGITS, 2, maximum decimal digits per operand; integrator guarantees 10^MAX_DIGITS-1 <= 2^WIDTH-1.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
key_valid  in  1  key_code valid this cycle; one key consumed per valid cycle, no backpressure
key_code  in  4  0-9 digit; 10 ADD; 11 SUB; 12 MUL; 13 EQ; 14 CLR; 15 reserved (ignored)
operand_a  out  WIDTH  registered operand A
operand_b  out  WIDTH  registered operand B
op_code  out  2  latched operator: 0 ADD, 1 SUB, 2 MUL
result  out  2*WIDTH+1  signed two's-complement result, registered
result_valid  out  1  high while state is RESULT
overflow  out  1  sticky: a truncated result was reused as operand A
state  out  3  current state encoding

Behaviour:
- Reset (reset=0, async): state=IDLE(0); operand_a, operand_b, op_code, result, overflow, digit counter = 0. Release takes effect on the next clk edge.
- States: IDLE=0, OPA=1, OPER=2, OPB=3, RESULT=4. Codes 5-7 are illegal and go to IDLE on the next edge with all registers cleared.
- Cycles without key_valid, and cycles with key_code 15: no change.
- CLR in any state: same effect as reset, applied synchronously at the next edge.
- Digit entry: operand <= operand*10 + digit; digit counter increments. When the counter is already MAX_DIGITS, the digit is ignored. The counter resets on entry of each new operand.
- IDLE:
  - digit: A=digit, count=1, go to OPA.
  - ADD/SUB/MUL/EQ: ignored.
- OPA:
  - digit: append to A.
  - operator: op_code=key, go to OPER.
  - EQ: ignored.
- OPER:
  - digit: B=digit, count=1, go to OPB.
  - operator: replaces op_code, stay in OPER.
  - EQ: ignored.
- OPB:
  - digit: append to B.
  - EQ: result <= A op B, go to RESULT.
  - operator (chaining): result <= A op B; A <= result[WIDTH-1:0]; B=0; op_code=new key; go to OPER.
- RESULT:
  - digit: A=digit, B=0, count=1, overflow=0, go to OPA.
  - operator: A <= result[WIDTH-1:0], B=0, op_code=key, go to OPER.
  - EQ: ignored, result held.
- Arithmetic: operands are zero-extended to 2*WIDTH+1 bits, then ADD/SUB/MUL. The result is exact and never wraps.
- Latency: result and result_valid update at the clk edge that samples the EQ key, i.e. visible 1 cycle after the EQ cycle.
- Overflow: set whenever a result is reused as A (chain or RESULT→operator) and the result is <0 or >2^WIDTH-1. It is cleared only by reset, CLR, or a digit in RESULT.
- result holds its last value in all states until the next computation or clear.

Test Plan:
1. Reset; keys 1,2,ADD,3,4,EQ → A=12, B=34, op_code=0; result=46 and result_valid=1 the cycle after EQ; state=4.
2. Digit limit and overflow: keys 1,2,3 → A=12 (3 ignored). Then MUL,9,9,EQ → result=1188. Then MUL → A=1188 mod 512=164, overflow=1, state=2. Then CLR → all zero, overflow=0.
3. Negative result: keys 5,SUB,9,EQ → result=−4 (19'h7FFFC), overflow=0. Then ADD → A=508, overflow=1.
4. Chaining and operator replacement: keys 2,ADD,3,MUL → A=5, op_code=2, state=OPER. Then SUB → op_code=1. Then 4,EQ → result=1.
5. Ignored keys: in IDLE press ADD, EQ, 15 → no change. In RESULT press EQ → result unchanged. Cycles with key_valid=0 → no change.
6. Async reset mid-operation: in OPB with A=7, B=3, drop reset between clock edges → all outputs 0 and state=0 immediately. After release, 4,ADD,1,EQ → result=5.
